// File: rtl/div_pkg.sv
// +-----------------------------------------------------------------------+
// | div_pkg: shared widths, state encoding and constants for div_32by16    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

package div_pkg;

    localparam int DVD_W = 32;
    localparam int DVS_W = 16;
    localparam int ITER  = 16;

    localparam logic [DVS_W-1:0] QUOT_SAT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// +-----------------------------------------------------------------------+
// | div_step: one restoring-division iteration (shift, compare, subtract)  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module div_step
    import div_pkg::*;
(
    input  logic [DVS_W:0]   rem_in,
    input  logic             dvd_bit,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVS_W:0]   rem_out,
    output logic             q_bit
);

    logic [DVS_W:0] shifted;

    // A set top bit means the true shifted value exceeds 2^17, so it always
    // dominates the divisor; the 17-bit difference is exact because the real
    // result is smaller than the divisor.
    assign shifted = {rem_in[DVS_W-1:0], dvd_bit};
    assign q_bit   = rem_in[DVS_W] | (shifted >= {1'b0, divisor});
    assign rem_out = q_bit ? (shifted - {1'b0, divisor}) : shifted;

endmodule

`default_nettype wire

// File: rtl/div_32by16.sv
// +-----------------------------------------------------------------------+
// | div_32by16: sequential 32/16 unsigned restoring divider, 1 bit/cycle   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module div_32by16
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVS_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int          CNT_W     = $clog2(ITER);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [DVS_W:0]   rem_p;
    logic [DVS_W-1:0] dvd_lo;
    logic [DVS_W-1:0] dvs;
    logic [DVS_W-2:0] q_work;
    logic [DVS_W:0]   rem_next;
    logic             q_bit;

    div_step u_step (
        .rem_in  (rem_p),
        .dvd_bit (dvd_lo[DVS_W-1]),
        .divisor (dvs),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            count       <= '0;
            rem_p       <= '0;
            dvd_lo      <= '0;
            dvs         <= '0;
            q_work      <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        count       <= '0;
                        busy        <= 1'b1;
                        if (divisor == '0) begin
                            div_by_zero <= 1'b1;
                            quotient    <= QUOT_SAT;
                            remainder   <= dividend[DVS_W-1:0];
                            done        <= 1'b1;
                            state       <= ST_DONE;
                        end else if (dividend[DVD_W-1:DVS_W] >= divisor) begin
                            // Quotient would need more than 16 bits
                            overflow    <= 1'b1;
                            quotient    <= QUOT_SAT;
                            remainder   <= dividend[DVS_W-1:0];
                            done        <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            rem_p  <= {1'b0, dividend[DVD_W-1:DVS_W]};
                            dvd_lo <= dividend[DVS_W-1:0];
                            dvs    <= divisor;
                            q_work <= '0;
                            state  <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    rem_p  <= rem_next;
                    dvd_lo <= {dvd_lo[DVS_W-2:0], 1'b0};
                    q_work <= {q_work[DVS_W-3:0], q_bit};
                    count  <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        quotient  <= {q_work, q_bit};
                        remainder <= rem_next[DVS_W-1:0];
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_32by16.sv
// +-----------------------------------------------------------------------+
// | tb_div_32by16: table-driven and random self-checking bench             |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_div_32by16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] dvd;
        logic [15:0] dvs;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
    } vec_t;

    localparam int NFIX = 8;
    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    logic [15:0] prev_q = 16'd0;
    logic [15:0] prev_r = 16'd0;

    div_32by16 dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [31:0] a, input logic [15:0] b);
        vec_t v;
        longint unsigned qq;
        v.dvd = a; v.dvs = b; v.dz = 1'b0; v.ov = 1'b0;
        if (b == 16'd0) begin
            v.dz = 1'b1; v.q = 16'hFFFF; v.r = a[15:0];
        end else begin
            qq = longint'(a) / longint'(b);
            if (qq > 65535) begin
                v.ov = 1'b1; v.q = 16'hFFFF; v.r = a[15:0];
            end else begin
                v.q = 16'(qq);
                v.r = 16'(longint'(a) % longint'(b));
            end
        end
        return v;
    endfunction

    // Issue one operation, scramble operands after acceptance, check
    // latency, results, hold behaviour and the single-cycle done pulse.
    task automatic run_op(input vec_t v, input string tag);
        int k;
        int exp_lat;
        bit hold_ok;
        exp_lat = (v.dz || v.ov) ? 0 : 16;
        @(negedge clk);
        start = 1'b1; dividend = v.dvd; divisor = v.dvs;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = 16'($urandom);
        chk({tag, " busy"}, {31'd0, busy}, 32'd1);
        hold_ok = 1'b1;
        k = 0;
        while (!done && k < 40) begin
            if (quotient !== prev_q || remainder !== prev_r) hold_ok = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'(exp_lat));
        if (exp_lat > 0) chk({tag, " hold"}, {31'd0, hold_ok}, 32'd1);
        chk({tag, " quotient"}, {16'd0, quotient}, {16'd0, v.q});
        chk({tag, " remainder"}, {16'd0, remainder}, {16'd0, v.r});
        chk({tag, " flags"}, {30'd0, div_by_zero, overflow}, {30'd0, v.dz, v.ov});
        @(posedge clk); #1;
        chk({tag, " idle"}, {30'd0, done, busy}, 32'd0);
        prev_q = v.q;
        prev_r = v.r;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        int pulses;
        logic [15:0] hi, lo, dvs;
        logic [31:0] dvd;

        vecs[0] = '{32'd100,        16'd7,      16'd14,     16'd2,      1'b0, 1'b0};
        vecs[1] = '{32'hFFFE0001,   16'hFFFF,   16'hFFFF,   16'h0000,   1'b0, 1'b0};
        vecs[2] = '{32'h00001234,   16'h0000,   16'hFFFF,   16'h1234,   1'b1, 1'b0};
        vecs[3] = '{32'h00010000,   16'h0001,   16'hFFFF,   16'h0000,   1'b0, 1'b1};
        vecs[4] = '{32'h00000000,   16'h0001,   16'h0000,   16'h0000,   1'b0, 1'b0};
        vecs[5] = '{32'hFFFEFFFF,   16'hFFFF,   16'hFFFF,   16'hFFFE,   1'b0, 1'b0};
        vecs[6] = '{32'h0000FFFF,   16'h0001,   16'hFFFF,   16'h0000,   1'b0, 1'b0};
        vecs[7] = '{32'h00050003,   16'h0005,   16'hFFFF,   16'h0003,   1'b0, 1'b1};
        for (int i = NFIX; i < NVEC; i++) begin
            dvs = 16'($urandom_range(1, 65535));
            if (i == NVEC - 1) begin
                dvs = 16'd0;
                dvd = $urandom;
            end else if (i % 4 == 3) begin
                dvd = $urandom;
            end else begin
                hi  = 16'($urandom % dvs);
                lo  = 16'($urandom);
                dvd = {hi, lo};
            end
            vecs[i] = model(dvd, dvs);
        end

        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        @(negedge clk); @(negedge clk);
        chk("reset q", {16'd0, quotient}, 32'd0);
        chk("reset r", {16'd0, remainder}, 32'd0);
        chk("reset flags", {28'd0, busy, done, div_by_zero, overflow}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++)
            run_op(vecs[i], $sformatf("vec%0d", i));

        // A second start during CALC must be ignored
        @(negedge clk);
        start = 1'b1; dividend = 32'd1000; divisor = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 5) begin start = 1'b1; dividend = 32'd50; divisor = 16'd5; end
            if (k == 6) start = 1'b0;
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("busy-start pulses", 32'(pulses), 32'd1);
        chk("busy-start quotient", {16'd0, quotient}, 32'd333);
        chk("busy-start remainder", {16'd0, remainder}, 32'd1);
        prev_q = quotient; prev_r = remainder;

        // Asynchronous reset mid-CALC
        @(negedge clk);
        start = 1'b1; dividend = 32'd60000; divisor = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        chk("async reset q", {16'd0, quotient}, 32'd0);
        chk("async reset r", {16'd0, remainder}, 32'd0);
        chk("async reset flags", {28'd0, busy, done, div_by_zero, overflow}, 32'd0);
        pulses = 0;
        repeat (3) begin @(posedge clk); #1; if (done) pulses++; end
        @(negedge clk);
        reset = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (done) pulses++; end
        chk("aborted no done", 32'(pulses), 32'd0);
        prev_q = 16'd0; prev_r = 16'd0;
        v = model(32'd9, 16'd2);
        chk("model 9/2", {v.q, v.r}, {16'd4, 16'd1});
        run_op(v, "after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
